truth_table_scanner: RTL

- Sequential sweep engine for the team's 4-input combinational logic blocks.
- Drives the logic block's input bus through every code 0..2^WIDTH-1 and samples the 1-bit result.
- Assembles the sampled results into a truth-table word and flags completion.
- Sits directly upstream of the logic block (feeds A) and consumes its OUT, replacing hand-written stimulus lists in hardware self-check.

---
 rtl/truth_table_scanner_pkg.sv | 20 ++
 rtl/truth_table_scanner_settle_counter.sv | 27 ++
 rtl/truth_table_scanner.sv | 121 ++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner (package tt_pkg).
// Optional minterm counter in the top is enabled by defining TT_ONES_COUNT_EN.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } tt_state_e;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

  function automatic int TT_WIDTH(input int w);
    return 2 ** w;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_counter.sv
// Loadable settle down-counter; o_zero marks the last DRIVE cycle of a code.
module tt_settle_counter
  import tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps a_out over every code, samples f_in per code and builds table_out.
// Define TT_ONES_COUNT_EN to add the ones_count (minterm count) output.
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [WIDTH-1:0]           a_out,
  input  logic                       f_in,
  output logic [TT_WIDTH(WIDTH)-1:0] table_out,
  output logic                       busy,
  output logic                       done
`ifdef TT_ONES_COUNT_EN
  ,
  output logic [WIDTH:0]             ones_count
`endif
);

  localparam int TW = TT_WIDTH(WIDTH);
  localparam int SETTLE_C = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                            (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_C - 1);
  localparam logic [WIDTH-1:0] A_LAST   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] A_ONE    = WIDTH'(1);

  tt_state_e        r_state;
  logic [WIDTH-1:0] r_a;
  logic [TW-1:0]    r_table;
  logic             r_busy;
  logic             r_done;
  logic             w_zero;
  logic             w_load;
  logic             w_dec;

  // Reload on scan acceptance and on every non-terminal SAMPLE.
  assign w_load = ((r_state == IDLE) && start) ||
                  ((r_state == SAMPLE) && (r_a != A_LAST));
  assign w_dec  = (r_state == DRIVE) && !w_zero;

  tt_settle_counter u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (CNT_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

`ifdef TT_ONES_COUNT_EN
  localparam logic [WIDTH:0] ONES_ONE = (WIDTH + 1)'(1);
  logic [WIDTH:0] r_ones;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ones <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_ones <= '0;
    end else if ((r_state == SAMPLE) && f_in) begin
      r_ones <= r_ones + ONES_ONE;
    end
  end

  assign ones_count = r_ones;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= DRIVE;
            r_a     <= '0;
            r_table <= '0;
            r_busy  <= 1'b1;
          end
        end
        DRIVE: begin
          if (w_zero) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_table[r_a] <= f_in;
          // Terminal code is caught explicitly so a_out never wraps.
          if (r_a == A_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_a     <= r_a + A_ONE;
            r_state <= DRIVE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a_out     = r_a;
  assign table_out = r_table;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
